fib_detector_seq: RTL and testbench

Sequential, width-parametrised Fibonacci-membership detector. It is the successor to the 4-bit combinational Fibonacci check in lab1. It accepts an N-bit operand on a start pulse, iterates a Fibonacci generator one term per clock, and reports whether the operand is a Fibonacci number and at which index. It sits as a standalone lab1 datapath block driven by a bench or a switch/button front end.

---
 rtl/fib_pkg.sv | 33 +++
 rtl/fib_if.sv | 15 +
 rtl/fib_detector_seq_step.sv | 24 ++
 rtl/fib_detector_seq.sv | 121 ++++++++++++
 tb/tb_fib_detector_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the sequential Fibonacci detector: FSM encoding and
// a constant helper giving the index of the first term that overflows N bits.
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fib_state_t;

    localparam int FIB_MAX_N = 32;

    // Largest k the generator can reach for width n (index of first overflowing term).
    function automatic int fib_max_index(input int n);
        longint a;
        longint b;
        longint t;
        int     k;
        a = 0;
        b = 1;
        k = 0;
        while (a < (longint'(1) << n)) begin
            t = a + b;
            a = b;
            b = t;
            k = k + 1;
        end
        return k;
    endfunction

    localparam int FIB_MAX_INDEX = fib_max_index(FIB_MAX_N);

endpackage

// File: rtl/fib_if.sv
// Request/result bundle between a requester and the Fibonacci detector.
interface fib_if #(
    parameter int N  = 16,
    parameter int IW = 6
);
    logic          start;
    logic [N-1:0]  x;
    logic          ready;
    logic          done;
    logic          is_fib;
    logic [IW-1:0] index;

    modport master (output start, output x, input ready, input done, input is_fib, input index);
    modport slave  (input start, input x, output ready, output done, output is_fib, output index);
endinterface

// File: rtl/fib_detector_seq_step.sv
// One Fibonacci advance: (a, b) -> (b, a+b) with sticky overflow tracking.
module fib_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic         a_ovf,
    input  logic [N-1:0] b,
    input  logic         b_ovf,
    output logic [N-1:0] a_nxt,
    output logic         a_ovf_nxt,
    output logic [N-1:0] b_nxt,
    output logic         b_ovf_nxt
);
    logic [N:0] sum;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        a_nxt     = b;
        a_ovf_nxt = b_ovf;
        b_nxt     = sum[N-1:0];
        // an overflowed input poisons every later term, even if the sum wraps small
        b_ovf_nxt = sum[N] | a_ovf | b_ovf;
    end
endmodule

// File: rtl/fib_detector_seq.sv
// Sequential Fibonacci-membership detector: walks the sequence one term per
// clock until the term matches, exceeds or overflows the latched operand.
module fib_detector_seq
    import fib_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = 6
) (
    input  logic clk,
    input  logic rst,
    fib_if.slave bus
);
    fib_state_t    state_q, state_d;
    logic [N-1:0]  xr_q, xr_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic          a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
    logic [IW-1:0] k_q, k_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          is_fib_q, is_fib_d;
    logic [IW-1:0] index_q, index_d;

    logic [N-1:0]  a_nxt, b_nxt;
    logic          a_ovf_nxt, b_ovf_nxt;

    fib_step #(.N(N)) u_step (
        .a        (a_q),
        .a_ovf    (a_ovf_q),
        .b        (b_q),
        .b_ovf    (b_ovf_q),
        .a_nxt    (a_nxt),
        .a_ovf_nxt(a_ovf_nxt),
        .b_nxt    (b_nxt),
        .b_ovf_nxt(b_ovf_nxt)
    );

    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        a_d      = a_q;
        b_d      = b_q;
        a_ovf_d  = a_ovf_q;
        b_ovf_d  = b_ovf_q;
        k_d      = k_q;
        done_d   = 1'b0;
        is_fib_d = is_fib_q;
        index_d  = index_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    xr_d     = bus.x;
                    a_d      = '0;
                    b_d      = {{(N-1){1'b0}}, 1'b1};
                    a_ovf_d  = 1'b0;
                    b_ovf_d  = 1'b0;
                    k_d      = '0;
                    is_fib_d = 1'b0;
                    index_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!a_ovf_q && (a_q == xr_q)) begin
                    is_fib_d = 1'b1;
                    index_d  = k_q;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (a_ovf_q || (a_q > xr_q)) begin
                    is_fib_d = 1'b0;
                    index_d  = '0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    a_d     = a_nxt;
                    a_ovf_d = a_ovf_nxt;
                    b_d     = b_nxt;
                    b_ovf_d = b_ovf_nxt;
                    k_d     = k_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            xr_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_ovf_q  <= 1'b0;
            b_ovf_q  <= 1'b0;
            k_q      <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            is_fib_q <= 1'b0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            xr_q     <= xr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_ovf_q  <= a_ovf_d;
            b_ovf_q  <= b_ovf_d;
            k_q      <= k_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            is_fib_q <= is_fib_d;
            index_q  <= index_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.is_fib = is_fib_q;
    assign bus.index  = index_q;
endmodule

// File: tb/tb_fib_detector_seq.sv
// Bench for fib_detector_seq at N=4 and N=16 against an arithmetic Fibonacci model.
module tb_fib_detector_seq;
    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst16 = 1'b1;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fib_if #(.N(4),  .IW(6)) if4 ();
    fib_if #(.N(16), .IW(6)) if16 ();

    fib_detector_seq #(.N(4),  .IW(6)) dut4  (.clk(clk), .rst(rst4),  .bus(if4.slave));
    fib_detector_seq #(.N(16), .IW(6)) dut16 (.clk(clk), .rst(rst16), .bus(if16.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walk the sequence with wide integers until the term reaches x; an
    // overflowing term is automatically larger than any N-bit x.
    function automatic void model(input longint x, output bit fib, output int idx, output int m);
        longint a;
        longint b;
        longint t;
        a = 0;
        b = 1;
        m = 0;
        while (a < x) begin
            t = a + b;
            a = b;
            b = t;
            m++;
        end
        fib = (a == x);
        idx = fib ? m : 0;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? if4.done : if16.done;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel == 0) ? if4.ready : if16.ready;
    endfunction
    function automatic logic get_fib(input int sel);
        return (sel == 0) ? if4.is_fib : if16.is_fib;
    endfunction
    function automatic logic [5:0] get_index(input int sel);
        return (sel == 0) ? if4.index : if16.index;
    endfunction

    task automatic drive(input int sel, input logic s, input logic [31:0] xv);
        if (sel == 0) begin
            if4.start = s;
            if4.x     = xv[3:0];
        end else begin
            if16.start = s;
            if16.x     = xv[15:0];
        end
    endtask

    // Returns #1 after the accepting edge t, with start already dropped.
    task automatic start_only(input int sel, input logic [31:0] xv);
        @(posedge clk); #1;
        chk("ready_before_start", get_ready(sel), 1'b1);
        drive(sel, 1'b1, xv);
        @(posedge clk); #1;
        drive(sel, 1'b0, xv);
    endtask

    // Latency reported as spec edge offset: done seen after edge t+j -> t+j+1.
    task automatic wait_done(input int sel, input int budget, input int j0, output int lat);
        int j;
        j = j0;
        while (!get_done(sel) && j < budget) begin
            @(posedge clk); #1;
            j++;
        end
        chk("done_within_budget", get_done(sel), 1'b1);
        lat = j + 1;
    endtask

    task automatic op_check(input int sel, input logic [31:0] xv, input int budget);
        bit fib;
        int idx;
        int m;
        int lat;
        string p;
        p = $sformatf("n%0d_x%0d", (sel == 0) ? 4 : 16, xv);
        model(longint'(xv), fib, idx, m);
        start_only(sel, xv);
        wait_done(sel, budget, 0, lat);
        chk({p, "_is_fib"}, get_fib(sel), fib);
        chk({p, "_index"}, get_index(sel), idx);
        chk({p, "_latency"}, lat, m + 2);
    endtask

    initial begin
        int lat;
        bit seen;
        longint fibs[$];
        longint fa;
        longint fb;
        longint ft;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst4  = 1'b0;
        rst16 = 1'b0;
        chk("reset_ready4", if4.ready, 1'b1);
        chk("reset_done4", if4.done, 1'b0);
        chk("reset_fib4", if4.is_fib, 1'b0);
        chk("reset_index4", if4.index, 6'd0);
        chk("reset_ready16", if16.ready, 1'b1);
        chk("reset_index16", if16.index, 6'd0);

        // exhaustive N=4, includes 15 which terminates through overflow
        for (int xv = 0; xv < 16; xv++) begin
            op_check(0, xv, 40);
            @(posedge clk); #1;
            chk("done_one_cycle", if4.done, 1'b0);
            chk("ready_after_done", if4.ready, 1'b1);
        end

        op_check(1, 46368, 40);
        op_check(1, 65535, 40);

        // start and x wiggled mid-run must not disturb the original operand
        start_only(0, 13);
        chk("ready_low_in_run", if4.ready, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 4);
        @(posedge clk); #1;
        drive(0, 1'b0, 9);
        wait_done(0, 40, 2, lat);
        chk("ignore_start_fib", if4.is_fib, 1'b1);
        chk("ignore_start_index", if4.index, 6'd7);
        chk("ignore_start_latency", lat, 9);

        // back-to-back: start issued in the DONE cycle
        op_check(0, 5, 40);
        chk("b2b_ready_in_done", if4.ready, 1'b1);
        drive(0, 1'b1, 8);
        @(posedge clk); #1;
        drive(0, 1'b0, 0);
        chk("b2b_result_cleared", if4.is_fib, 1'b0);
        chk("b2b_in_run", if4.ready, 1'b0);
        wait_done(0, 40, 0, lat);
        chk("b2b_fib", if4.is_fib, 1'b1);
        chk("b2b_index", if4.index, 6'd6);
        chk("b2b_latency", lat, 8);

        // reset while processing 13
        start_only(0, 13);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        chk("rst_mid_ready", if4.ready, 1'b1);
        chk("rst_mid_done", if4.done, 1'b0);
        chk("rst_mid_fib", if4.is_fib, 1'b0);
        chk("rst_mid_index", if4.index, 6'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if4.done) seen = 1'b1;
        end
        chk("rst_mid_no_done", seen, 1'b0);
        op_check(0, 8, 40);

        // random N=16 operands, half drawn from the sequence itself
        fa = 0;
        fb = 1;
        while (fa < 65536) begin
            fibs.push_back(fa);
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] xv;
            if ($urandom_range(0, 1) == 1)
                xv = 32'(fibs[$urandom_range(0, fibs.size() - 1)]);
            else
                xv = $urandom_range(0, 65535);
            op_check(1, xv, 40);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
